// File: rtl/mmio_timer_pkg.sv
// Shared definitions for the memory-mapped timer peripheral.
//
// Contents:
//   - Register indices. These are used for both the one-hot write strobes and the read address.
//   - CTRL and STATUS bit positions.
//   - Operating-state enum. The state is derived from CTRL.EN and is never stored separately.
package mmio_timer_pkg;

  // Register map. The write decoder and the read mux share this map.
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_LOAD   = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  // CTRL field positions. PRESC occupies PRESC_W bits starting at CTRL_PRESC_LSB.
  localparam int unsigned CTRL_EN        = 0;
  localparam int unsigned CTRL_RELOAD    = 1;
  localparam int unsigned CTRL_IE        = 2;
  localparam int unsigned CTRL_PRESC_LSB = 8;

  // STATUS field positions.
  localparam int unsigned STATUS_TF = 0;

  // Operating state, decoded from CTRL.EN.
  typedef enum logic {
    StIdle,
    StRun
  } timer_state_e;

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler for the MMIO timer.
//
// The counter advances once per cycle while enable is high. When the count equals presc, the
// block asserts tick for that cycle and the counter wraps to 0 at the same edge. A presc of 0
// therefore gives a tick on every enabled cycle.
//
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - asynchronous active-low reset
//   enable - count while high; hold while low
//   clear  - synchronous clear of the counter; takes priority over counting
//   presc  - divide value; the tick period is presc+1 cycles
//   tick   - one-cycle pulse when the counter wraps (combinational from the counter)
module timer_prescaler #(
  parameter int unsigned PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               clear,
  input  logic [PRESC_W-1:0] presc,
  output logic               tick
);

  logic [PRESC_W-1:0] cnt_q, cnt_d;
  logic               wrap;

  always_comb begin
    wrap  = (cnt_q == presc);
    tick  = enable & wrap;
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mmio_timer_regs.sv
// Memory-mapped timer with four registers: CTRL, LOAD, COUNT and STATUS.
//
// The block sits behind a 2-to-4 write decoder and takes that decoder's one-hot strobes.
// COUNT is a down-counter driven by a prescaled tick. When a tick arrives with COUNT at 0, the
// timer expires and sets the sticky TF flag. After expiry it either reloads COUNT from LOAD
// (RELOAD=1) or clears EN and stops (RELOAD=0). The interrupt is TF & IE.
//
// Ports:
//   i_clk    - system clock, rising edge
//   i_rst_n  - asynchronous active-low reset
//   i_wsel   - one-hot write strobes: bit0 CTRL, bit1 LOAD, bit2 COUNT, bit3 STATUS
//   i_wdata  - write data
//   i_raddr  - read register index, using the same map as i_wsel
//   o_rdata  - read data, a combinational mux of the current register values
//   o_irq    - interrupt request, TF & IE (driven only from registers)
module mmio_timer_regs
  import mmio_timer_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned PRESC_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [3:0]        i_wsel,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [1:0]        i_raddr,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_irq
);

  // Register state
  logic               en_q, en_d;
  logic               reload_q, reload_d;
  logic               ie_q, ie_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [DATA_W-1:0]  load_q, load_d;
  logic [DATA_W-1:0]  count_q, count_d;
  logic               tf_q, tf_d;

  // Decoded strobes and events
  logic         wr_ctrl, wr_load, wr_count, wr_status;
  logic         presc_tick;
  logic         presc_clear;
  logic         run_tick;
  logic         expire;
  timer_state_e state;

  assign wr_ctrl   = i_wsel[REG_CTRL];
  assign wr_load   = i_wsel[REG_LOAD];
  assign wr_count  = i_wsel[REG_COUNT];
  assign wr_status = i_wsel[REG_STATUS];

  // Restart the prescaler phase whenever software reloads the count or starts the timer. This
  // makes the first expiry land (LOAD+1)*(PRESC+1) cycles later.
  assign presc_clear = wr_load | wr_count | (wr_ctrl & i_wdata[CTRL_EN] & ~en_q);

  timer_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_prescaler (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .enable (en_q),
    .clear  (presc_clear),
    .presc  (presc_q),
    .tick   (presc_tick)
  );

  // A CPU write to LOAD or COUNT in the same cycle as a tick takes priority, and the tick is
  // discarded.
  assign run_tick = presc_tick & ~(wr_load | wr_count);
  assign expire   = run_tick & (count_q == '0);

  always_comb begin
    state    = en_q ? StRun : StIdle;
    en_d     = en_q;
    reload_d = reload_q;
    ie_d     = ie_q;
    presc_d  = presc_q;
    load_d   = load_q;
    count_d  = count_q;
    tf_d     = tf_q;

    // Hardware count behaviour
    unique case (state)
      StIdle: begin
        // COUNT and the prescaler hold
      end
      StRun: begin
        if (run_tick) begin
          if (count_q != '0) begin
            count_d = count_q - 1'b1;
          end else if (reload_q) begin
            count_d = load_q;
          end else begin
            en_d = 1'b0;
          end
        end
      end
    endcase

    // CPU writes are applied after the hardware update so that they override it.
    if (wr_ctrl) begin
      en_d     = i_wdata[CTRL_EN];
      reload_d = i_wdata[CTRL_RELOAD];
      ie_d     = i_wdata[CTRL_IE];
      presc_d  = i_wdata[CTRL_PRESC_LSB +: PRESC_W];
    end
    if (wr_load) begin
      load_d  = i_wdata;
      count_d = i_wdata;
    end
    if (wr_count) begin
      count_d = i_wdata;
    end

    // TF: if an expiry and a write-1-to-clear happen in the same cycle, the set wins.
    if (expire) begin
      tf_d = 1'b1;
    end else if (wr_status && i_wdata[STATUS_TF]) begin
      tf_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      en_q     <= 1'b0;
      reload_q <= 1'b0;
      ie_q     <= 1'b0;
      presc_q  <= '0;
      load_q   <= '0;
      count_q  <= '0;
      tf_q     <= 1'b0;
    end else begin
      en_q     <= en_d;
      reload_q <= reload_d;
      ie_q     <= ie_d;
      presc_q  <= presc_d;
      load_q   <= load_d;
      count_q  <= count_d;
      tf_q     <= tf_d;
    end
  end

  // Read mux. Unused bits read as 0.
  always_comb begin
    o_rdata = '0;
    unique case (i_raddr)
      REG_CTRL: begin
        o_rdata[CTRL_EN]                    = en_q;
        o_rdata[CTRL_RELOAD]                = reload_q;
        o_rdata[CTRL_IE]                    = ie_q;
        o_rdata[CTRL_PRESC_LSB +: PRESC_W]  = presc_q;
      end
      REG_LOAD:   o_rdata = load_q;
      REG_COUNT:  o_rdata = count_q;
      REG_STATUS: o_rdata[STATUS_TF] = tf_q;
    endcase
  end

  assign o_irq = tf_q & ie_q;

endmodule

// File: tb/tb_mmio_timer_regs.sv
module tb_mmio_timer_regs;

  localparam logic [3:0] W_CTRL   = 4'b0001;
  localparam logic [3:0] W_LOAD   = 4'b0010;
  localparam logic [3:0] W_COUNT  = 4'b0100;
  localparam logic [3:0] W_STATUS = 4'b1000;

  logic        i_clk   = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [3:0]  i_wsel  = 4'b0;
  logic [31:0] i_wdata = 32'b0;
  logic [1:0]  i_raddr = 2'b0;
  logic [31:0] o_rdata;
  logic        o_irq;

  int unsigned pass_cnt  = 0;
  int unsigned total_cnt = 0;

  always #5 i_clk = ~i_clk;

  mmio_timer_regs #(
    .DATA_W  (32),
    .PRESC_W (8)
  ) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_wsel  (i_wsel),
    .i_wdata (i_wdata),
    .i_raddr (i_raddr),
    .o_rdata (o_rdata),
    .o_irq   (o_irq)
  );

  // Reference model. 'since' is the number of enabled cycles since the prescaler phase was last
  // restarted. A tick falls on every (presc+1)-th such cycle.
  typedef struct packed {
    logic        en;
    logic        reload;
    logic        ie;
    logic [7:0]  presc;
    logic [31:0] load;
    logic [31:0] count;
    logic        tf;
    logic [31:0] since;
  } mstate_t;

  mstate_t m;

  function automatic mstate_t model_next(input mstate_t s, input logic [3:0] ws,
                                         input logic [31:0] wd);
    mstate_t     n;
    logic        tick;
    logic        expire;
    logic [31:0] period;
    n      = s;
    period = {24'b0, s.presc} + 32'd1;
    tick   = s.en && ((s.since % period) == period - 32'd1) && !ws[1] && !ws[2];
    expire = tick && (s.count == 32'd0);
    if (s.en) n.since = s.since + 32'd1;
    if (tick) begin
      if (expire) begin
        n.tf = 1'b1;
        if (s.reload) n.count = s.load;
        else          n.en    = 1'b0;
      end else begin
        n.count = s.count - 32'd1;
      end
    end
    if (ws[3] && wd[0] && !expire) n.tf = 1'b0;
    if (ws[0]) begin
      n.en     = wd[0];
      n.reload = wd[1];
      n.ie     = wd[2];
      n.presc  = wd[15:8];
      if (wd[0] && !s.en) n.since = 32'd0;
    end
    if (ws[1]) begin
      n.load  = wd;
      n.count = wd;
      n.since = 32'd0;
    end
    if (ws[2]) begin
      n.count = wd;
      n.since = 32'd0;
    end
    return n;
  endfunction

  function automatic logic [31:0] exp_rdata(input mstate_t s, input logic [1:0] a);
    logic [31:0] r;
    case (a)
      2'd0:    r = {31'b0, s.en} | ({31'b0, s.reload} << 1) | ({31'b0, s.ie} << 2)
                   | ({24'b0, s.presc} << 8);
      2'd1:    r = s.load;
      2'd2:    r = s.count;
      default: r = {31'b0, s.tf};
    endcase
    return r;
  endfunction

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) m <= '0;
    else          m <= model_next(m, i_wsel, i_wdata);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  // Compare the DUT against the model every cycle, away from the active edge.
  always @(negedge i_clk) begin
    check("model_rdata", o_rdata, exp_rdata(m, i_raddr));
    check("model_irq", {31'b0, o_irq}, {31'b0, m.tf & m.ie});
  end

  // Drivers. Inputs change 2 ns after the active edge.
  task automatic wr(input logic [3:0] sel, input logic [31:0] data);
    i_wsel  = sel;
    i_wdata = data;
    @(posedge i_clk);
    #2;
    i_wsel  = 4'b0;
    i_wdata = 32'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #2;
    end
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
    i_raddr = a;
    #1;
    check(name, o_rdata, exp);
  endtask

  task automatic irq_chk(input logic exp, input string name);
    check(name, {31'b0, o_irq}, {31'b0, exp});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    // Reset held, with random write traffic
    i_rst_n = 1'b0;
    repeat (6) begin
      i_wsel  = 4'($urandom_range(0, 15));
      i_wdata = $urandom;
      @(posedge i_clk);
      #2;
      for (int a = 0; a < 4; a++) rd(a[1:0], 32'h0, "rst_rdata");
      irq_chk(1'b0, "rst_irq");
    end
    i_wsel  = 4'b0;
    i_wdata = 32'b0;
    i_rst_n = 1'b1;
    idle(50);
    rd(2'd2, 32'h0, "post_rst_count");
    rd(2'd3, 32'h0, "post_rst_tf");
    rd(2'd0, 32'h0, "post_rst_ctrl");

    // One-shot: LOAD=3, EN|IE, PRESC=0
    wr(W_LOAD, 32'd3);
    wr(W_CTRL, 32'h0000_0005);
    rd(2'd2, 32'd3, "os_count3");
    rd(2'd0, 32'h5, "os_ctrl");
    idle(1); rd(2'd2, 32'd2, "os_count2");
    idle(1); rd(2'd2, 32'd1, "os_count1");
    idle(1); rd(2'd2, 32'd0, "os_count0");
    rd(2'd3, 32'd0, "os_tf_early");
    irq_chk(1'b0, "os_irq_early");
    idle(1);
    rd(2'd3, 32'd1, "os_tf");
    irq_chk(1'b1, "os_irq");
    rd(2'd0, 32'h4, "os_en_cleared");
    rd(2'd2, 32'd0, "os_count_zero");
    idle(3); rd(2'd2, 32'd0, "os_count_hold");
    wr(W_STATUS, 32'd1);
    rd(2'd3, 32'd0, "os_w1c");
    irq_chk(1'b0, "os_irq_cleared");

    // Auto-reload: LOAD=1, EN|RELOAD, PRESC=2 -> expiry every 6 cycles
    wr(W_LOAD, 32'd1);
    wr(W_CTRL, 32'h0000_0203);
    idle(5);
    rd(2'd3, 32'd0, "ar_tf_before");
    rd(2'd2, 32'd0, "ar_count_mid");
    idle(1);
    rd(2'd3, 32'd1, "ar_tf_expiry");
    rd(2'd2, 32'd1, "ar_reloaded");
    irq_chk(1'b0, "ar_irq_masked");
    idle(5);
    rd(2'd3, 32'd1, "ar_tf_sticky");
    rd(2'd2, 32'd0, "ar_count_before2");
    wr(W_STATUS, 32'd1);  // Lands on the second expiry edge
    rd(2'd3, 32'd1, "w1c_race_set_wins");
    rd(2'd2, 32'd1, "ar_reloaded2");
    wr(W_STATUS, 32'd1);
    rd(2'd3, 32'd0, "w1c_clear");
    wr(W_CTRL, 32'h0);

    // Write vs tick with PRESC=0
    wr(W_COUNT, 32'd10);
    wr(W_CTRL, 32'h1);
    idle(1); rd(2'd2, 32'd9, "wt_count9");
    wr(W_COUNT, 32'd7);
    rd(2'd2, 32'd7, "wt_write_wins");
    idle(1); rd(2'd2, 32'd6, "wt_dec");

    // Mid-run reset clears asynchronously
    idle(1); rd(2'd2, 32'd5, "mr_count5");
    i_rst_n = 1'b0;
    rd(2'd2, 32'd0, "mr_async_count");
    rd(2'd0, 32'd0, "mr_async_ctrl");
    @(posedge i_clk);
    #2;
    i_rst_n = 1'b1;
    idle(3);
    rd(2'd0, 32'd0, "mr_en_off");
    rd(2'd2, 32'd0, "mr_count_hold");
    rd(2'd3, 32'd0, "mr_tf_clear");

    // CTRL write in a RELOAD=0 expiry cycle: the CPU's EN wins
    wr(W_LOAD, 32'd0);
    wr(W_CTRL, 32'h1);
    wr(W_CTRL, 32'h1);
    rd(2'd0, 32'h1, "race_en_kept");
    rd(2'd3, 32'd1, "race_tf");
    idle(1);
    rd(2'd0, 32'h0, "race_en_hw_clear");
    rd(2'd2, 32'd0, "race_count_zero");

    // IE masks the IRQ without touching TF
    wr(W_CTRL, 32'h4);
    irq_chk(1'b1, "ie_irq_on");
    wr(W_CTRL, 32'h0);
    irq_chk(1'b0, "ie_irq_masked");
    rd(2'd3, 32'd1, "ie_tf_kept");

    // Several strobes at once write each selected register
    wr(4'b0110, 32'd9);
    rd(2'd1, 32'd9, "multi_load");
    rd(2'd2, 32'd9, "multi_count");

    idle(2);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
